// File: rtl/alu_share_arbiter_pkg.sv
// Shared types for alu_share_arbiter: opcode and FSM state encodings.
package alu_share_arbiter_pkg;

    localparam int OP_WIDTH = 3;

    typedef enum logic [OP_WIDTH-1:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        ADC = 3'd2,
        SBB = 3'd3,
        SHL = 3'd4,
        SHR = 3'd5,
        SAR = 3'd6,
        CMP = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/CLAA.sv
// Carry-lookahead adder: s_o = a_i + b_i + c_i, c_o = carry-out.
module CLAA #(
    parameter int WORD_WIDTH = 16
) (
    input  logic [WORD_WIDTH-1:0] a_i,
    input  logic [WORD_WIDTH-1:0] b_i,
    input  logic                  c_i,
    output logic [WORD_WIDTH-1:0] s_o,
    output logic                  c_o
);

    logic [WORD_WIDTH-1:0] gen;
    logic [WORD_WIDTH-1:0] prop;
    logic [WORD_WIDTH:0]   carry;

    assign gen  = a_i & b_i;
    assign prop = a_i ^ b_i;

    // Carry chain from generate/propagate terms
    always_comb begin
        carry    = '0;
        carry[0] = c_i;
        for (int unsigned i = 0; i < WORD_WIDTH; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
    end

    assign s_o = prop ^ carry[WORD_WIDTH-1:0];
    assign c_o = carry[WORD_WIDTH];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or after ptr.
module rr_arbiter #(
    parameter int REQ_NUM = 4
) (
    input  logic [REQ_NUM-1:0]         req,
    input  logic [$clog2(REQ_NUM)-1:0] ptr,
    output logic [REQ_NUM-1:0]         grant,
    output logic [$clog2(REQ_NUM)-1:0] grant_id
);

    localparam int IDW = $clog2(REQ_NUM);

    // Scan requesters starting at ptr, wrapping at REQ_NUM
    always_comb begin
        int unsigned idx;
        logic        found;
        idx      = 0;
        found    = 1'b0;
        grant    = '0;
        grant_id = '0;
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= 32'(REQ_NUM)) begin
                idx = idx - 32'(REQ_NUM);
            end
            if (!found && req[idx]) begin
                found       = 1'b1;
                grant[idx]  = 1'b1;
                grant_id    = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one add/sub/shift unit between
// REQ_NUM requesters, with a tagged response channel.
// Define ALU_SHARE_ARBITER_CARRY_CHAIN_EN to keep a carry flag per requester
// for ADC/SBB; otherwise ADC acts as ADD and SBB as SUB.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int REQ_NUM    = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [REQ_NUM-1:0]            req_valid_i,
    output logic [REQ_NUM-1:0]            req_ready_o,
    input  logic [3*REQ_NUM-1:0]          req_op_i,
    input  logic [WORD_WIDTH*REQ_NUM-1:0] req_a_i,
    input  logic [WORD_WIDTH*REQ_NUM-1:0] req_b_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [$clog2(REQ_NUM)-1:0]    rsp_id_o,
    output logic [WORD_WIDTH-1:0]         rsp_result_o,
    output logic                          rsp_carry_o,
    output logic                          rsp_zero_o
);

    localparam int IDW = $clog2(REQ_NUM);
    localparam int SW  = $clog2(WORD_WIDTH);

    arb_state_e            state;
    logic [IDW-1:0]        rr_ptr;
    logic [IDW-1:0]        id_q;
    alu_op_e               op_q;
    logic [WORD_WIDTH-1:0] a_q;
    logic [WORD_WIDTH-1:0] b_q;
`ifdef ALU_SHARE_ARBITER_CARRY_CHAIN_EN
    logic [REQ_NUM-1:0]    cf;
`endif

    logic [REQ_NUM-1:0]    grant;
    logic [IDW-1:0]        grant_id;

    logic [WORD_WIDTH-1:0] add_b;
    logic                  add_cin;
    logic [WORD_WIDTH-1:0] sum;
    logic                  sum_cout;

    logic [SW-1:0]         amt;
    logic [SW:0]           left_idx;
    logic [WORD_WIDTH-1:0] shl_res;
    logic [WORD_WIDTH-1:0] shr_res;
    logic [WORD_WIDTH-1:0] sar_res;
    logic                  shl_c;
    logic                  shr_c;

    logic [WORD_WIDTH-1:0] result;
    logic                  carry;

    rr_arbiter #(.REQ_NUM(REQ_NUM)) u_rr_arbiter (
        .req      (req_valid_i),
        .ptr      (rr_ptr),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req_ready_o = (state == IDLE && !rst_i) ? grant : '0;

    // Adder operand/carry-in selection per opcode
    always_comb begin
        add_b   = b_q;
        add_cin = 1'b0;
        case (op_q)
            SUB, CMP: begin
                add_b   = ~b_q;
                add_cin = 1'b1;
            end
            ADC: begin
`ifdef ALU_SHARE_ARBITER_CARRY_CHAIN_EN
                add_cin = cf[id_q];
`else
                add_cin = 1'b0;
`endif
            end
            SBB: begin
                add_b   = ~b_q;
`ifdef ALU_SHARE_ARBITER_CARRY_CHAIN_EN
                add_cin = cf[id_q];
`else
                add_cin = 1'b1;
`endif
            end
            default: begin
                add_b   = b_q;
                add_cin = 1'b0;
            end
        endcase
    end

    CLAA #(.WORD_WIDTH(WORD_WIDTH)) u_claa (
        .a_i (a_q),
        .b_i (add_b),
        .c_i (add_cin),
        .s_o (sum),
        .c_o (sum_cout)
    );

    // Local shifter; carry is the last bit shifted out, zero for amount 0
    always_comb begin
        amt      = b_q[SW-1:0];
        left_idx = (SW+1)'(WORD_WIDTH) - {1'b0, amt};
        shl_res  = a_q << amt;
        shr_res  = a_q >> amt;
        sar_res  = $unsigned($signed(a_q) >>> amt);
        shl_c    = (amt != '0) & a_q[left_idx[SW-1:0]];
        shr_c    = (amt != '0) & a_q[amt - SW'(1)];
    end

    // Result/carry selection between shifter and adder
    always_comb begin
        result = sum;
        carry  = sum_cout;
        case (op_q)
            SHL: begin
                result = shl_res;
                carry  = shl_c;
            end
            SHR: begin
                result = shr_res;
                carry  = shr_c;
            end
            SAR: begin
                result = sar_res;
                carry  = shr_c;
            end
            default: begin
                result = sum;
                carry  = sum_cout;
            end
        endcase
    end

    // Control FSM with registered response outputs and carry state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            id_q         <= '0;
            op_q         <= ADD;
            a_q          <= '0;
            b_q          <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_id_o     <= '0;
            rsp_result_o <= '0;
            rsp_carry_o  <= 1'b0;
            rsp_zero_o   <= 1'b0;
`ifdef ALU_SHARE_ARBITER_CARRY_CHAIN_EN
            cf           <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid_i) begin
                        op_q  <= alu_op_e'(req_op_i[3*grant_id +: 3]);
                        a_q   <= req_a_i[WORD_WIDTH*grant_id +: WORD_WIDTH];
                        b_q   <= req_b_i[WORD_WIDTH*grant_id +: WORD_WIDTH];
                        id_q  <= grant_id;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result_o <= result;
                    rsp_carry_o  <= carry;
                    rsp_zero_o   <= (result == '0);
                    rsp_id_o     <= id_q;
                    rsp_valid_o  <= 1'b1;
`ifdef ALU_SHARE_ARBITER_CARRY_CHAIN_EN
                    cf[id_q]     <= carry;
`endif
                    state        <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        rr_ptr      <= (id_q == IDW'(REQ_NUM-1)) ? '0 : id_q + IDW'(1);
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter (WORD_WIDTH=16, REQ_NUM=4).
`timescale 1ns/1ps
module tb_alu_share_arbiter;

    localparam int W = 16;
    localparam int N = 4;

`ifdef ALU_SHARE_ARBITER_CARRY_CHAIN_EN
    localparam logic [15:0] ADC_EXP = 16'h0001;
    localparam logic [15:0] SBB_EXP = 16'hFFFD;
`else
    localparam logic [15:0] ADC_EXP = 16'h0000;
    localparam logic [15:0] SBB_EXP = 16'hFFFE;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [3*N-1:0] req_op;
    logic [W*N-1:0] req_a;
    logic [W*N-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_result;
    logic           rsp_carry;
    logic           rsp_zero;

    int checks = 0;
    int errors = 0;
    int unsigned cf_m [N];

    typedef struct {
        int          k;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] r;
        logic        c;
    } vec_t;

    vec_t tv [15];

    always #5 clk = ~clk;

    alu_share_arbiter #(.WORD_WIDTH(W), .REQ_NUM(N)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_result_o (rsp_result),
        .rsp_carry_o  (rsp_carry),
        .rsp_zero_o   (rsp_zero)
    );

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Reference: arithmetic on wide integers straight from the opcode rules
    function automatic void model(input int k, input int unsigned op, input int unsigned a,
                                  input int unsigned b, output int unsigned r, output int unsigned c);
        int unsigned s, nb, amt, cin;
        s = 0; r = 0; c = 0; cin = 0;
        nb  = (~b) & 32'hFFFF;
        amt = b & 15;
        case (op)
            0: s = a + b;
            1, 7: s = a + nb + 1;
            2: begin
`ifdef ALU_SHARE_ARBITER_CARRY_CHAIN_EN
                cin = cf_m[k];
`else
                cin = 0;
`endif
                s = a + b + cin;
            end
            3: begin
`ifdef ALU_SHARE_ARBITER_CARRY_CHAIN_EN
                cin = cf_m[k];
`else
                cin = 1;
`endif
                s = a + nb + cin;
            end
            4: begin
                r = (a << amt) & 32'hFFFF;
                c = (amt != 0) ? ((a >> (16 - amt)) & 1) : 0;
            end
            5: begin
                r = a >> amt;
                c = (amt != 0) ? ((a >> (amt - 1)) & 1) : 0;
            end
            default: begin
                r = a;
                for (int unsigned i = 0; i < amt; i++) begin
                    c = r & 1;
                    r = (r >> 1) | (r & 32'h8000);
                end
            end
        endcase
        if (op < 4 || op == 7) begin
            r = s & 32'hFFFF;
            c = (s >> 16) & 1;
        end
        cf_m[k] = c;
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < N; i++) cf_m[i] = 0;
    endtask

    // One request on requester k; returns the observed response. Call just after a posedge.
    task automatic issue(input int k, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input int stall, output logic [15:0] r, output logic c, output logic z,
                         output logic [1:0] id);
        int n;
        req_valid          = '0;
        req_op[3*k +: 3]   = op;
        req_a[16*k +: 16]  = a;
        req_b[16*k +: 16]  = b;
        req_valid[k]       = 1'b1;
        rsp_ready          = (stall == 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 20);
        chk("grant", 32'(req_ready), 32'(1) << k);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        chk("lat_n1_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        chk("lat_n2_valid", 32'(rsp_valid), 1);
        r  = rsp_result;
        c  = rsp_carry;
        z  = rsp_zero;
        id = rsp_id;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("hold_rsp", 32'({rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_result}),
                32'({1'b1, id, c, z, r}));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] r;
        logic        c, z;
        logic [1:0]  id;
        int unsigned mr, mc;
        int          n, ngr, cyc;
        int          gid [6];
        int          gc  [6];
        logic [21:0] snap;

        tv[0]  = '{1, 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1};
        tv[1]  = '{3, 3'd0, 16'h0001, 16'h0001, 16'h0002, 1'b0};
        tv[2]  = '{1, 3'd2, 16'h0000, 16'h0000, ADC_EXP,  1'b0};
        tv[3]  = '{2, 3'd5, 16'h8001, 16'h0001, 16'h4000, 1'b1};
        tv[4]  = '{2, 3'd6, 16'h8000, 16'h0003, 16'hF000, 1'b0};
        tv[5]  = '{2, 3'd4, 16'h0001, 16'h0000, 16'h0001, 1'b0};
        tv[6]  = '{0, 3'd1, 16'h0005, 16'h0003, 16'h0002, 1'b1};
        tv[7]  = '{0, 3'd1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0};
        tv[8]  = '{0, 3'd3, 16'h0003, 16'h0005, SBB_EXP,  1'b0};
        tv[9]  = '{3, 3'd7, 16'h1234, 16'h1234, 16'h0000, 1'b1};
        tv[10] = '{2, 3'd4, 16'h8001, 16'h0001, 16'h0002, 1'b1};
        tv[11] = '{1, 3'd4, 16'h0001, 16'h002F, 16'h8000, 1'b0};
        tv[12] = '{3, 3'd6, 16'h7FFF, 16'h0004, 16'h07FF, 1'b1};
        tv[13] = '{0, 3'd2, 16'h8000, 16'h8000, 16'h0000, 1'b1};
        tv[14] = '{0, 3'd3, 16'h0000, 16'h0000, 16'h0000, 1'b1};

        req_op = '0; req_a = '0; req_b = '0;
        do_reset();

        // Reset state
        @(negedge clk);
        chk("rst_ready",  32'(req_ready),  0);
        chk("rst_valid",  32'(rsp_valid),  0);
        chk("rst_id",     32'(rsp_id),     0);
        chk("rst_result", 32'(rsp_result), 0);
        chk("rst_carry",  32'(rsp_carry),  0);
        chk("rst_zero",   32'(rsp_zero),   0);
        @(posedge clk); #1;

        // Single ADD on req0
        issue(0, 3'd0, 16'h1234, 16'h0001, 0, r, c, z, id);
        model(0, 0, 32'h1234, 32'h0001, mr, mc);
        chk("add_result", 32'(r), 32'h1235);
        chk("add_carry",  32'(c), 0);
        chk("add_zero",   32'(z), 0);
        chk("add_id",     32'(id), 0);

        // Round-robin order with all four requesting
        do_reset();
        for (int k = 0; k < N; k++) begin
            req_op[3*k +: 3]  = 3'd0;
            req_a[16*k +: 16] = 16'(k);
            req_b[16*k +: 16] = 16'h0010;
            gid[k] = -1; gc[k] = -1;
        end
        gid[4] = -1; gid[5] = -1; gc[4] = -1; gc[5] = -1;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        ngr = 0; cyc = 0;
        while (ngr < 6 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (req_ready != '0) begin
                int g;
                g = -1;
                chk("rr_onehot", 32'($countones(req_ready)), 1);
                for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
                gid[ngr] = g;
                gc[ngr]  = cyc;
                ngr++;
                @(posedge clk);
                #1 req_valid[g] = 1'b0;
                if (ngr == 4) begin
                    req_valid[0] = 1'b1;
                    req_valid[2] = 1'b1;
                end
            end
        end
        chk("rr_grant_count", 32'(ngr), 6);
        for (int i = 0; i < 4; i++) chk("rr_order", 32'(gid[i]), 32'(i));
        for (int i = 1; i < 6; i++) chk("rr_spacing", 32'(gc[i] - gc[i-1]), 3);
        chk("rr_regrant0", 32'(gid[4]), 0);
        chk("rr_regrant2", 32'(gid[5]), 2);
        repeat (3) @(posedge clk);
        #1;

        // Vector table (multi-word chain, shifts, subtracts, compare)
        do_reset();
        for (int i = 0; i < 15; i++) begin
            issue(tv[i].k, tv[i].op, tv[i].a, tv[i].b, i % 3, r, c, z, id);
            model(tv[i].k, 32'(tv[i].op), 32'(tv[i].a), 32'(tv[i].b), mr, mc);
            chk($sformatf("vec%0d_result", i), 32'(r), 32'(tv[i].r));
            chk($sformatf("vec%0d_carry", i),  32'(c), 32'(tv[i].c));
            chk($sformatf("vec%0d_zero", i),   32'(z), 32'(tv[i].r == 16'h0000));
            chk($sformatf("vec%0d_id", i),     32'(id), 32'(tv[i].k));
        end

        // Backpressure with all requests valid
        for (int k = 0; k < N; k++) begin
            req_op[3*k +: 3]  = 3'd0;
            req_a[16*k +: 16] = 16'(16'h0100 * k + 1);
            req_b[16*k +: 16] = 16'h0001;
        end
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 10);
        chk("bp_valid", 32'(rsp_valid), 1);
        snap = {rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_result};
        id   = rsp_id;
        model(int'(id), 0, 32'h0100 * id + 1, 1, mr, mc);
        chk("bp_result", 32'(rsp_result), mr);
        chk("bp_carry",  32'(rsp_carry),  mc);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("bp_hold",  32'({rsp_valid, rsp_id, rsp_carry, rsp_zero, rsp_result}), 32'(snap));
            chk("bp_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_next_grant", 32'(req_ready), 32'(1) << ((int'(id) + 1) % N));
        @(posedge clk);
        #1 req_valid = '0;
        model((int'(id) + 1) % N, 0, 32'h0100 * ((int'(id) + 1) % N) + 1, 1, mr, mc);
        repeat (3) @(posedge clk);
        #1;

        // Reset while in EXEC discards the operation and clears carry state
        issue(0, 3'd0, 16'hFFFF, 16'h0001, 0, r, c, z, id);
        model(0, 0, 32'hFFFF, 1, mr, mc);
        chk("pre_rst_result", 32'(r), 0);
        chk("pre_rst_carry",  32'(c), 1);
        req_op[2:0] = 3'd0;
        req_a[15:0] = 16'h0003;
        req_b[15:0] = 16'h0004;
        req_valid   = 4'b0001;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ready == '0 && n < 20);
        chk("exec_rst_grant", 32'(req_ready), 1);
        @(posedge clk);
        #1 req_valid = '0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < N; i++) cf_m[i] = 0;
        @(negedge clk);
        chk("exec_rst_outputs", 32'({req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero}), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("exec_rst_no_rsp", 32'(rsp_valid), 0);
        end
        @(posedge clk); #1;
        issue(0, 3'd2, 16'h0000, 16'h0000, 0, r, c, z, id);
        model(0, 2, 0, 0, mr, mc);
        chk("post_rst_adc_result", 32'(r), 0);
        chk("post_rst_adc_carry",  32'(c), 0);
        chk("post_rst_adc_zero",   32'(z), 1);

        // Randomized single operations against the reference model
        for (int i = 0; i < 80; i++) begin
            int          k, st;
            logic [2:0]  op;
            logic [15:0] a, b;
            k  = $urandom_range(0, 3);
            op = 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            b  = (op >= 3'd4 && op <= 3'd6) ? 16'($urandom_range(0, 15)) : 16'($urandom);
            st = $urandom_range(0, 2);
            issue(k, op, a, b, st, r, c, z, id);
            model(k, 32'(op), 32'(a), 32'(b), mr, mc);
            chk("rnd_result", 32'(r),  mr);
            chk("rnd_carry",  32'(c),  mc);
            chk("rnd_zero",   32'(z),  32'(mr == 0));
            chk("rnd_id",     32'(id), 32'(k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
